// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: bus slave with TX FIFO, programmable
// baud divider and a frame FSM driving uart_tx_o.
module uart_tx_periph #(
  parameter int unsigned FifoDepth      = 8,
  parameter int unsigned BaudDivDefault = 217,
  parameter logic [31:0] BaseAddrMask   = 32'h0000_000F
) (
  input  logic        clk_sys,
  input  logic        rst_sys_n,
  input  logic        req_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        uart_tx_o,
  output logic        tx_idle_o
);

  localparam int unsigned     PtrW      = $clog2(FifoDepth);
  localparam int unsigned     CntW      = PtrW + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(FifoDepth);
  localparam logic [15:0]     MinDiv    = 16'd2;
  localparam logic [15:0]     ResetDiv  = 16'(BaudDivDefault);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_STATUS = 2'd1,
    REG_BAUD   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_e;

  // Address decode
  logic [31:0] offset;
  reg_e        reg_sel;
  logic        wr_txdata;
  logic        wr_status_clr;
  logic        wr_baud;

  assign offset        = addr_i & BaseAddrMask;
  assign reg_sel       = reg_e'(offset[3:2]);
  assign wr_txdata     = req_i && we_i && (reg_sel == REG_TXDATA) && be_i[0];
  assign wr_status_clr = req_i && we_i && (reg_sel == REG_STATUS) && be_i[0] && wdata_i[3];
  assign wr_baud       = req_i && we_i && (reg_sel == REG_BAUD);

  // State registers
  state_e          state_q;
  logic            tx_q;
  logic [7:0]      shift_q;
  logic [15:0]     bit_cnt_q;
  logic [2:0]      bit_idx_q;
  logic [15:0]     div_q;

  logic            rvalid_q;
  logic [31:0]     rdata_q, rdata_d;
  logic [15:0]     baud_div_q, baud_div_d;
  logic            overflow_q, overflow_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic [7:0]      fifo_mem [FifoDepth];
  logic [7:0]      fifo_rdata;
  logic            fifo_full, fifo_empty;
  logic            push, pop, busy;
  logic [15:0]     div_eff;

  assign fifo_full  = (count_q == FullCount);
  assign fifo_empty = (count_q == '0);
  assign fifo_rdata = fifo_mem[rd_ptr_q];
  assign busy       = (state_q != IDLE);
  assign div_eff    = (baud_div_q < MinDiv) ? MinDiv : baud_div_q;

  // The FSM pops when idle, or at the last cycle of a stop bit for back-to-back frames.
  assign pop  = !fifo_empty &&
                ((state_q == IDLE) || ((state_q == STOP) && (bit_cnt_q == '0)));
  assign push = wr_txdata && (!fifo_full || pop);

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    rdata_d    = '0;
    baud_div_d = baud_div_q;
    overflow_d = overflow_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (req_i && !we_i) begin
      unique case (reg_sel)
        REG_STATUS: rdata_d = {28'd0, overflow_q, busy, fifo_empty, fifo_full};
        REG_BAUD:   rdata_d = {16'd0, baud_div_q};
        default:    rdata_d = '0;
      endcase
    end

    if (wr_baud) begin
      if (be_i[0]) baud_div_d[7:0]  = wdata_i[7:0];
      if (be_i[1]) baud_div_d[15:8] = wdata_i[15:8];
    end

    if (wr_txdata && fifo_full && !pop) begin
      overflow_d = 1'b1;
    end else if (wr_status_clr) begin
      overflow_d = 1'b0;
    end

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: FIFO storage has no reset; only entries covered by count_q are ever read.
  always_ff @(posedge clk_sys) begin
    if (push) fifo_mem[wr_ptr_q] <= wdata_i[7:0];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      baud_div_q <= ResetDiv;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      rvalid_q   <= req_i;
      rdata_q    <= rdata_d;
      baud_div_q <= baud_div_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Frame FSM; the divisor is captured at each pop so BAUD_DIV writes affect the next frame.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q   <= IDLE;
      tx_q      <= 1'b1;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      div_q     <= MinDiv;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            shift_q   <= fifo_rdata;
            div_q     <= div_eff;
            bit_cnt_q <= div_eff - 16'd1;
            tx_q      <= 1'b0;
            state_q   <= START;
          end
        end
        START: begin
          if (bit_cnt_q == '0) begin
            bit_cnt_q <= div_q - 16'd1;
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
            state_q   <= DATA;
          end else begin
            bit_cnt_q <= bit_cnt_q - 16'd1;
          end
        end
        DATA: begin
          if (bit_cnt_q == '0) begin
            bit_cnt_q <= div_q - 16'd1;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
            end
          end else begin
            bit_cnt_q <= bit_cnt_q - 16'd1;
          end
        end
        STOP: begin
          if (bit_cnt_q == '0) begin
            if (pop) begin
              shift_q   <= fifo_rdata;
              div_q     <= div_eff;
              bit_cnt_q <= div_eff - 16'd1;
              tx_q      <= 1'b0;
              state_q   <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q - 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o     = req_i;
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;
  assign uart_tx_o = tx_q;
  assign tx_idle_o = fifo_empty && (state_q == IDLE);

  logic unused_bits;
  assign unused_bits = ^{offset[31:4], offset[1:0], wdata_i[31:16], be_i[3:2]};

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph: bus map, frame timing, FIFO overflow,
// divisor latching and asynchronous reset.
module tb_uart_tx_periph;

  logic        clk_sys   = 1'b0;
  logic        rst_sys_n = 1'b0;
  logic        req_i     = 1'b0;
  logic        we_i      = 1'b0;
  logic [3:0]  be_i      = 4'h0;
  logic [31:0] addr_i    = '0;
  logic [31:0] wdata_i   = '0;
  logic        gnt_o, rvalid_o, uart_tx_o, tx_idle_o;
  logic [31:0] rdata_o;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] A_TX = 32'h0, A_ST = 32'h4, A_BD = 32'h8, A_RS = 32'hC;

  uart_tx_periph #(.FifoDepth(8), .BaudDivDefault(217), .BaseAddrMask(32'h0000_000F)) dut (
    .clk_sys   (clk_sys),
    .rst_sys_n (rst_sys_n),
    .req_i     (req_i),
    .gnt_o     (gnt_o),
    .rvalid_o  (rvalid_o),
    .we_i      (we_i),
    .be_i      (be_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .rdata_o   (rdata_o),
    .uart_tx_o (uart_tx_o),
    .tx_idle_o (tx_idle_o)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // rvalid must follow each granted request by exactly one cycle; grant mirrors request.
  logic exp_rv;
  always @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) exp_rv <= 1'b0;
    else            exp_rv <= req_i;
  end
  always @(negedge clk_sys) begin
    check("rvalid_follow", {31'd0, rvalid_o}, {31'd0, exp_rv});
    check("gnt_eq_req", {31'd0, gnt_o}, {31'd0, req_i});
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called #1 after a posedge; returns #1 after the next posedge.
  task automatic bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata, input string tag);
    req_i = 1'b1; we_i = we; addr_i = addr; be_i = be; wdata_i = wdata;
    @(posedge clk_sys); #1;
    req_i = 1'b0; we_i = 1'b0; be_i = 4'h0;
    check({tag, "_rvalid"}, {31'd0, rvalid_o}, 32'd1);
    check({tag, "_rdata"}, rdata_o, exp_rdata);
  endtask

  task automatic sync();
    @(posedge clk_sys); #1;
  endtask

  task automatic do_reset();
    req_i = 1'b0;
    rst_sys_n = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1 rst_sys_n = 1'b1;
    sync();
  endtask

  // Waits for a start bit, then checks every cycle of the 8N1 frame and that tx_idle_o stays low.
  // gap = negedges spent waiting after the first one; 0 means the start follows immediately.
  task automatic frame(input logic [7:0] b, input int div, input string tag, output int gap);
    int errs;
    errs = 0;
    gap  = 0;
    @(negedge clk_sys);
    while (uart_tx_o === 1'b1 && gap < 20000) begin
      @(negedge clk_sys);
      gap++;
    end
    check({tag, "_start_seen"}, {31'd0, uart_tx_o}, 32'd0);
    for (int i = 0; i < 10 * div; i++) begin
      int   k;
      logic e;
      k = i / div;
      e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      if (i > 0) @(negedge clk_sys);
      if (uart_tx_o !== e || tx_idle_o !== 1'b0) errs++;
    end
    check({tag, "_bits"}, errs, 0);
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk_sys);
    check({tag, "_tx_idle"}, {31'd0, tx_idle_o}, 32'd1);
    check({tag, "_line_high"}, {31'd0, uart_tx_o}, 32'd1);
  endtask

  initial begin
    int          g;
    int          lows;
    logic [15:0] def_div;
    logic [7:0]  ovf_bytes [10];

    def_div = 16'd217;
    for (int i = 0; i < 10; i++) ovf_bytes[i] = 8'(8'h40 + i * 7);

    // Reset state
    do_reset();
    check("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_tx", {31'd0, uart_tx_o}, 32'd1);
    check("rst_tx_idle", {31'd0, tx_idle_o}, 32'd1);
    bus(1'b0, A_ST, 4'hF, 0, 32'h2, "rst_status");
    bus(1'b0, A_BD, 4'hF, 0, 32'd217, "rst_baud");
    bus(1'b0, A_TX, 4'hF, 0, 32'd0, "txdata_read");
    bus(1'b1, A_RS, 4'hF, 32'hFFFF_FFFF, 32'd0, "rsvd_write");
    bus(1'b0, A_RS, 4'hF, 0, 32'd0, "rsvd_read");

    // Single 0x55 frame at divisor 4: starts two cycles after the write's grant cycle
    bus(1'b1, A_BD, 4'b0011, 32'd4, 32'd0, "t1_baud");
    bus(1'b1, A_TX, 4'b0001, 32'h55, 32'd0, "t1_write");
    frame(8'h55, 4, "t1", g);
    check("t1_gap", g, 1);
    expect_idle("t1_end");

    // Three back-to-back writes at divisor 2 give contiguous frames
    sync();
    bus(1'b1, A_BD, 4'b0011, 32'd2, 32'd0, "t2_baud");
    fork
      begin
        bus(1'b1, A_TX, 4'b0001, 32'hA1, 32'd0, "t2_w0");
        bus(1'b1, A_TX, 4'b0001, 32'hB2, 32'd0, "t2_w1");
        bus(1'b1, A_TX, 4'b0001, 32'hC3, 32'd0, "t2_w2");
      end
      begin
        frame(8'hA1, 2, "t2_f0", g);
        check("t2_gap0", g, 2);
        frame(8'hB2, 2, "t2_f1", g);
        check("t2_gap1", g, 0);
        frame(8'hC3, 2, "t2_f2", g);
        check("t2_gap2", g, 0);
      end
    join
    expect_idle("t2_end");

    // Overflow: one byte moves straight into the shifter, eight fill the FIFO, the tenth is dropped
    sync();
    bus(1'b1, A_BD, 4'b0011, 32'd1000, 32'd0, "t3_baud");
    fork
      begin
        for (int i = 0; i < 10; i++) bus(1'b1, A_TX, 4'b0001, {24'd0, ovf_bytes[i]}, 32'd0, "t3_w");
        bus(1'b0, A_ST, 4'hF, 0, 32'hD, "t3_status_ovf");
        bus(1'b1, A_ST, 4'b0001, 32'h8, 32'd0, "t3_clear");
        bus(1'b0, A_ST, 4'hF, 0, 32'h5, "t3_status_clr");
        bus(1'b1, A_BD, 4'b0011, 32'd2, 32'd0, "t3_baud2");
        bus(1'b0, A_BD, 4'hF, 0, 32'd2, "t3_baud2_rd");
      end
      begin
        frame(ovf_bytes[0], 1000, "t3_f0", g);
        for (int i = 1; i < 9; i++) begin
          frame(ovf_bytes[i], 2, "t3_fn", g);
          check("t3_gap", g, 0);
        end
      end
    join
    expect_idle("t3_end");
    lows = 0;
    repeat (30) begin
      @(negedge clk_sys);
      if (uart_tx_o !== 1'b1) lows++;
    end
    check("t3_no_tenth_frame", lows, 0);

    // Byte-gated divisor write from reset value; divisor 0 behaves as 2
    do_reset();
    bus(1'b1, A_BD, 4'b0001, 32'h1234, 32'd0, "t4_baud_lo");
    bus(1'b0, A_BD, 4'hF, 0, {16'd0, def_div[15:8], 8'h34}, "t4_baud_rd");
    bus(1'b1, A_BD, 4'b1111, 32'd0, 32'd0, "t4_baud_zero");
    bus(1'b0, A_BD, 4'hF, 0, 32'd0, "t4_baud_zero_rd");
    bus(1'b1, A_TX, 4'b0001, 32'h3C, 32'd0, "t4_write");
    frame(8'h3C, 2, "t4", g);
    check("t4_gap", g, 1);
    expect_idle("t4_end");

    // Divisor change mid-frame only affects the following frame
    sync();
    bus(1'b1, A_BD, 4'b0011, 32'd4, 32'd0, "t5_baud4");
    fork
      begin
        bus(1'b1, A_TX, 4'b0001, 32'h96, 32'd0, "t5_w0");
        bus(1'b1, A_TX, 4'b0001, 32'h5A, 32'd0, "t5_w1");
        repeat (5) @(posedge clk_sys);
        #1;
        bus(1'b1, A_BD, 4'b0011, 32'd8, 32'd0, "t5_baud8");
      end
      begin
        frame(8'h96, 4, "t5_f0", g);
        check("t5_gap0", g, 2);
        frame(8'h5A, 8, "t5_f1", g);
        check("t5_gap1", g, 0);
      end
    join
    expect_idle("t5_end");

    // Asynchronous reset in the middle of the data bits discards frame and FIFO
    sync();
    bus(1'b1, A_BD, 4'b0011, 32'd4, 32'd0, "t6_baud");
    bus(1'b1, A_TX, 4'b0001, 32'h00, 32'd0, "t6_w0");
    bus(1'b1, A_TX, 4'b0001, 32'h81, 32'd0, "t6_w1");
    repeat (10) @(posedge clk_sys);
    #1;
    check("t6_pre_reset_low", {31'd0, uart_tx_o}, 32'd0);
    rst_sys_n = 1'b0;
    #1;
    check("t6_async_line_high", {31'd0, uart_tx_o}, 32'd1);
    check("t6_async_idle", {31'd0, tx_idle_o}, 32'd1);
    repeat (2) @(posedge clk_sys);
    #1 rst_sys_n = 1'b1;
    sync();
    bus(1'b0, A_ST, 4'hF, 0, 32'h2, "t6_status");
    lows = 0;
    repeat (20) begin
      @(negedge clk_sys);
      if (uart_tx_o !== 1'b1) lows++;
    end
    check("t6_no_frame_after_reset", lows, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
